// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit arbiter.
//   arb_state_t             - arbiter FSM state encoding
//   TIMEOUT_CYCLES_DEFAULT  - default idle budget inside a message
//   TO_W                    - width of the in-message idle counter
//   onehot_of()             - requester index to one-hot grant vector
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_HOLD    = 2'd3
    } arb_state_t;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 65535;
    localparam int          TO_W                   = 16;

    function automatic logic [1:0] onehot_of(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between two byte-stream
// requesters, arbitrating round-robin at message boundaries.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/data/last     requester N offers a byte (last = end of message)
//   reqN_ready               one-cycle acceptance pulse for requester N
//   uart_txd                 byte presented to the UART (held when idle)
//   uart_enable_send         UART send request
//   uart_data_sent           UART completion flag
//   grant                    one-hot message owner, 2'b00 when none
//   busy                     high whenever the FSM is not in IDLE
//   timeout_err              one-cycle pulse when an idle owner is dropped
//
// Handshake: a requester holds valid/data/last stable until it observes
// reqN_ready=1; that registered pulse acknowledges the byte captured on the
// preceding clock edge, after which the requester may present its next byte.
// Byte transfer to the UART is a level handshake: enable_send stays high
// until data_sent is seen high, then the arbiter waits for data_sent to fall.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] uart_txd,
    output logic       uart_enable_send,
    input  logic       uart_data_sent,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    arb_state_t      state;
    logic            prio1;    // 1: requester 1 wins a tie in IDLE
    logic            last_q;   // captured byte ends the message
    logic            armed;    // data_sent has been low since this byte was captured
    logic [TO_W-1:0] to_cnt;

    logic       win_idx;
    logic [7:0] win_data;
    logic       win_last;
    logic       own_idx;
    logic       own_valid;
    logic [7:0] own_data;
    logic       own_last;

    // Tie goes to the requester that was not granted last.
    always_comb begin
        win_idx = req1_valid;
        if (req0_valid && req1_valid) begin
            win_idx = prio1;
        end
        win_data = win_idx ? req1_data : req0_data;
        win_last = win_idx ? req1_last : req0_last;
    end

    always_comb begin
        own_idx   = grant[1];
        own_valid = own_idx ? req1_valid : req0_valid;
        own_data  = own_idx ? req1_data  : req0_data;
        own_last  = own_idx ? req1_last  : req0_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            prio1            <= 1'b0;
            last_q           <= 1'b0;
            armed            <= 1'b0;
            to_cnt           <= '0;
            grant            <= 2'b00;
            busy             <= 1'b0;
            uart_txd         <= 8'h00;
            uart_enable_send <= 1'b0;
            req0_ready       <= 1'b0;
            req1_ready       <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            req0_ready  <= 1'b0;
            req1_ready  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        grant            <= onehot_of(win_idx);
                        prio1            <= ~win_idx;
                        uart_txd         <= win_data;
                        last_q           <= win_last;
                        armed            <= ~uart_data_sent;
                        req0_ready       <= ~win_idx;
                        req1_ready       <= win_idx;
                        uart_enable_send <= 1'b1;
                        busy             <= 1'b1;
                        state            <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // A data_sent level left over from an abandoned byte must
                    // drop once before it can complete this one.
                    if (uart_data_sent && armed) begin
                        uart_enable_send <= 1'b0;
                        state            <= ST_RELEASE;
                    end else if (!uart_data_sent) begin
                        armed <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!uart_data_sent) begin
                        if (last_q) begin
                            grant <= 2'b00;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            to_cnt <= '0;
                            state  <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (own_valid) begin
                        uart_txd         <= own_data;
                        last_q           <= own_last;
                        armed            <= ~uart_data_sent;
                        req0_ready       <= ~own_idx;
                        req1_ready       <= own_idx;
                        uart_enable_send <= 1'b1;
                        state            <= ST_SEND;
                    end else if (to_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        grant       <= 2'b00;
                        busy        <= 1'b0;
                        to_cnt      <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed bench for uart_tx_arbiter with
// a loopback UART model, queue-driven requesters and a message-level
// reference model of the round-robin order.
module tb_uart_tx_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       req0_valid = 1'b0;
    logic [7:0] req0_data  = 8'h00;
    logic       req0_last  = 1'b0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data  = 8'h00;
    logic       req1_last  = 1'b0;
    logic       req1_ready;
    logic [7:0] uart_txd;
    logic       uart_enable_send;
    logic       uart_data_sent = 1'b0;
    logic [1:0] grant;
    logic       busy;
    logic       timeout_err;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .req0_valid       (req0_valid),
        .req0_data        (req0_data),
        .req0_last        (req0_last),
        .req0_ready       (req0_ready),
        .req1_valid       (req1_valid),
        .req1_data        (req1_data),
        .req1_last        (req1_last),
        .req1_ready       (req1_ready),
        .uart_txd         (uart_txd),
        .uart_enable_send (uart_enable_send),
        .uart_data_sent   (uart_data_sent),
        .grant            (grant),
        .busy             (busy),
        .timeout_err      (timeout_err)
    );

    // ---------------- bench state ----------------
    int n_checks   = 0;
    int n_err      = 0;
    int cyc        = 0;
    int hold_entry = 0;
    int n_to       = 0;
    int n_r1       = 0;
    int model_last = 1;   // requester granted last; 1 after reset so req0 wins a tie
    int gap0 = 0, gap1 = 0, ucnt = 0, dcnt = 0;
    bit gap_en    = 1'b0;
    bit uart_hold = 1'b0;

    logic [9:0] exp_q[$];              // {owner grant, byte} in UART order
    logic [8:0] src0_q[$], src1_q[$];  // {last, byte} still to offer
    logic [8:0] stage0[$], stage1[$];  // bytes staged for the next commit

    logic       prev_en  = 1'b0;
    logic [7:0] prev_txd = 8'h00;
    logic [1:0] prev_r   = 2'b00;
    logic       prev_to  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- monitor, UART model, requester drivers ----------------
    always @(posedge clk) begin
        logic [1:0] r;
        logic [9:0] e;
        logic [8:0] p;
        cyc = cyc + 1;
        #1;
        r = {req1_ready, req0_ready};
        if (req1_ready) n_r1++;
        if (r != 2'b00) begin
            check_eq("rdy_owner", 32'(grant), 32'(r));
            check_eq("rdy_latency", 32'(uart_enable_send), 32'(1));
            check_eq("rdy_consec", 32'(prev_r), 32'(0));
        end
        check_eq("grant_1hot", 32'($countones(grant) <= 1), 32'(1));
        check_eq("busy_grant", 32'(busy), 32'(grant != 2'b00));
        if (uart_enable_send && prev_en) check_eq("txd_stable", 32'(uart_txd), 32'(prev_txd));
        if (!uart_enable_send && !rst)   check_eq("txd_hold", 32'(uart_txd), 32'(prev_txd));
        if (timeout_err) begin
            n_to++;
            check_eq("to_delay", 32'(cyc - hold_entry), 32'(16));
            check_eq("to_grant", 32'(grant), 32'(0));
            check_eq("to_pulse", 32'(prev_to), 32'(0));
        end
        prev_en  = uart_enable_send;
        prev_txd = uart_txd;
        prev_r   = r;
        prev_to  = timeout_err;

        // loopback UART: completes a byte after a random delay
        if (rst) begin
            uart_data_sent = 1'b0;
            ucnt = $urandom_range(0, 3);
        end else if (uart_enable_send && !uart_data_sent) begin
            if (!uart_hold) begin
                if (ucnt == 0) begin
                    uart_data_sent = 1'b1;
                    dcnt = $urandom_range(0, 2);
                    if (exp_q.size() == 0) begin
                        check_eq("uart_extra", 32'(exp_q.size()), 32'(1));
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("uart_byte", 32'(uart_txd), 32'(e[7:0]));
                        check_eq("uart_owner", 32'(grant), 32'(e[9:8]));
                    end
                end else begin
                    ucnt--;
                end
            end
        end else if (!uart_enable_send && uart_data_sent) begin
            if (dcnt == 0) begin
                uart_data_sent = 1'b0;
                hold_entry = cyc + 1;
                ucnt = $urandom_range(0, 3);
            end else begin
                dcnt--;
            end
        end

        // requesters: advance on ready, optional idle gap inside a message
        if (req0_ready && src0_q.size() > 0) begin
            p = src0_q.pop_front();
            if (!p[8] && gap_en) gap0 = $urandom_range(0, 4);
        end
        if (req1_ready && src1_q.size() > 0) begin
            p = src1_q.pop_front();
            if (!p[8] && gap_en) gap1 = $urandom_range(0, 4);
        end
        if (gap0 > 0) begin
            gap0--;
            req0_valid = 1'b0;
        end else begin
            req0_valid = (src0_q.size() > 0);
            if (src0_q.size() > 0) {req0_last, req0_data} = src0_q[0];
        end
        if (gap1 > 0) begin
            gap1--;
            req1_valid = 1'b0;
        end else begin
            req1_valid = (src1_q.size() > 0);
            if (src1_q.size() > 0) {req1_last, req1_data} = src1_q[0];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic stage_byte(input int rq, input logic [7:0] d, input logic l);
        if (rq == 0) stage0.push_back({l, d});
        else         stage1.push_back({l, d});
    endtask

    // Reference order: whole messages, ties go to the requester not granted last.
    task automatic commit();
        logic [8:0] a0[$];
        logic [8:0] a1[$];
        logic [8:0] b;
        int who;
        @(negedge clk);
        a0 = stage0;
        a1 = stage1;
        while (a0.size() > 0 || a1.size() > 0) begin
            if (a0.size() > 0 && a1.size() > 0) who = (model_last == 0) ? 1 : 0;
            else                                who = (a0.size() > 0) ? 0 : 1;
            model_last = who;
            do begin
                b = (who == 1) ? a1.pop_front() : a0.pop_front();
                exp_q.push_back({(who == 1) ? 2'b10 : 2'b01, b[7:0]});
            end while (!b[8] && ((who == 1) ? a1.size() : a0.size()) > 0);
        end
        foreach (stage0[i]) src0_q.push_back(stage0[i]);
        foreach (stage1[i]) src1_q.push_back(stage1[i]);
        stage0.delete();
        stage1.delete();
    endtask

    task automatic wait_drain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #2;
            if (src0_q.size() == 0 && src1_q.size() == 0 && exp_q.size() == 0 &&
                !busy && !req0_valid && !req1_valid) done = 1'b1;
        end
        check_eq("drain", 32'(done), 32'(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_last = 1;
        gap0 = 0;
        gap1 = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_en"},    32'(uart_enable_send), 32'(0));
        check_eq({tag, "_txd"},   32'(uart_txd),         32'(0));
        check_eq({tag, "_grant"}, 32'(grant),            32'(0));
        check_eq({tag, "_busy"},  32'(busy),             32'(0));
        check_eq({tag, "_rdy0"},  32'(req0_ready),       32'(0));
        check_eq({tag, "_rdy1"},  32'(req1_ready),       32'(0));
        check_eq({tag, "_to"},    32'(timeout_err),      32'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit seen;
        int snap;

        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;

        // two-byte message from requester 0
        stage_byte(0, 8'h41, 1'b0);
        stage_byte(0, 8'h42, 1'b1);
        commit();
        wait_drain(500);
        check_eq("msg2_busy",  32'(busy),  32'(0));
        check_eq("msg2_grant", 32'(grant), 32'(0));

        // simultaneous single-byte requests, fairness across rounds
        do_reset();
        stage_byte(0, 8'h11, 1'b1);
        stage_byte(1, 8'h22, 1'b1);
        commit();
        wait_drain(500);
        stage_byte(0, 8'h11, 1'b1);
        stage_byte(1, 8'h22, 1'b1);
        commit();
        wait_drain(500);
        stage_byte(0, 8'h13, 1'b1);
        commit();
        wait_drain(500);
        stage_byte(0, 8'h11, 1'b1);
        stage_byte(1, 8'h22, 1'b1);
        commit();
        wait_drain(500);

        // requester 1 waits while requester 0 is mid-message
        @(negedge clk);
        src0_q.push_back(9'h055);
        exp_q.push_back({2'b01, 8'h55});
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (req0_ready) seen = 1'b1;
        end
        check_eq("mid_acc", 32'(seen), 32'(1));
        @(negedge clk);
        src1_q.push_back(9'h166);
        snap = n_r1;
        repeat (8) @(negedge clk);
        check_eq("mid_r1_blocked", 32'(n_r1 - snap), 32'(0));
        src0_q.push_back(9'h10A);
        exp_q.push_back({2'b01, 8'h0A});
        exp_q.push_back({2'b10, 8'h66});
        model_last = 1;
        wait_drain(500);
        check_eq("mid_no_to", 32'(n_to), 32'(0));

        // owner goes quiet inside a message
        @(negedge clk);
        src0_q.push_back(9'h033);
        exp_q.push_back({2'b01, 8'h33});
        model_last = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (n_to == 1) seen = 1'b1;
        end
        check_eq("to_seen", 32'(seen), 32'(1));
        check_eq("to_busy", 32'(busy), 32'(0));
        @(negedge clk);
        src1_q.push_back(9'h177);
        exp_q.push_back({2'b10, 8'h77});
        model_last = 1;
        wait_drain(500);

        // reset while a byte is being sent
        uart_hold = 1'b1;
        @(negedge clk);
        src0_q.push_back(9'h15A);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (uart_enable_send) seen = 1'b1;
        end
        check_eq("rst_send_seen", 32'(seen), 32'(1));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check_reset_outputs("rst_send");
        @(negedge clk);
        rst = 1'b0;
        uart_hold = 1'b0;
        model_last = 1;
        stage_byte(0, 8'h3C, 1'b1);
        commit();
        wait_drain(500);

        // randomized message mixes
        gap_en = 1'b1;
        for (int rnd = 0; rnd < 20; rnd++) begin
            for (int rq = 0; rq < 2; rq++) begin
                int nm = $urandom_range(0, 3);
                for (int m = 0; m < nm; m++) begin
                    int len = $urandom_range(1, 4);
                    for (int k = 0; k < len; k++)
                        stage_byte(rq, 8'($urandom_range(0, 255)), k == len - 1);
                end
            end
            commit();
            wait_drain(2000);
        end

        check_eq("exp_left", 32'(exp_q.size()), 32'(0));
        check_eq("to_count", 32'(n_to), 32'(1));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
